pc_sequencer: RTL and testbench

//  Next-PC controller for the fetch stage: computes npc for the PC register every cycle and

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC sequencer and fetch handshake controller; optional PC_SEQ_MISALIGN_TRAP_EN
module pc_sequencer #(
    parameter int                  WIDTH_PC  = 32,
    parameter logic [WIDTH_PC-1:0] BOOT_ADDR = '0,
    parameter logic [WIDTH_PC-1:0] PC_STEP   = WIDTH_PC'(4)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH_PC-1:0] pc,
    output logic [WIDTH_PC-1:0] npc,
    input  logic                stall,
    input  logic                jump_en,
    input  logic [WIDTH_PC-1:0] jump_pc,
    input  logic                br_taken,
    input  logic [WIDTH_PC-1:0] br_pc,
    input  logic                trap_en,
    input  logic [WIDTH_PC-1:0] trap_vec,
    output logic                imem_req,
    output logic [WIDTH_PC-1:0] imem_addr,
    input  logic                imem_ack,
    output logic                if_valid,
    output logic                flush_id,
    output logic                flush_ex,
    output logic                misalign_trap
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH_PC-1:0] redir_q, redir_d;

    logic                redirect;
    logic [WIDTH_PC-1:0] raw_tgt;
    logic [WIDTH_PC-1:0] tgt;
    logic                misalign;
    logic                redir_fex;
    logic [WIDTH_PC-1:0] pc_inc;

    assign redirect = trap_en | br_taken | jump_en;
    assign raw_tgt  = trap_en ? trap_vec : (br_taken ? br_pc : jump_pc);
    assign pc_inc   = pc + PC_STEP;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    // Misaligned branch/jump target diverts to the trap vector; trap_vec is trusted.
    assign misalign = !trap_en && (br_taken || jump_en) && (raw_tgt[1:0] != 2'b00);
    assign tgt      = misalign ? trap_vec : raw_tgt;
`else
    // Without the trap, branch/jump targets are silently word-aligned.
    assign misalign = 1'b0;
    assign tgt      = trap_en ? trap_vec : (raw_tgt & ~WIDTH_PC'(3));
`endif

    // A misalignment trap kills EX just like a real trap.
    assign redir_fex = trap_en | br_taken | misalign;

    // Fetch address only meaningful while a request is up; zero otherwise.
    assign imem_addr = imem_req ? pc : '0;

    // State and pending-redirect target registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
        end
    end

    // Next-state, next-PC and handshake/flush outputs.
    always_comb begin
        state_d       = state_q;
        redir_d       = redir_q;
        npc           = pc;
        imem_req      = 1'b0;
        if_valid      = 1'b0;
        flush_id      = 1'b0;
        flush_ex      = 1'b0;
        misalign_trap = 1'b0;
        case (state_q)
            BOOT: begin
                npc     = BOOT_ADDR;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (redirect) begin
                    npc           = tgt;
                    flush_id      = 1'b1;
                    flush_ex      = redir_fex;
                    misalign_trap = misalign;
                end else if (!stall) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if_valid = 1'b1;
                        npc      = pc_inc;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Request stays up regardless of stall until the fetch completes.
                imem_req = 1'b1;
                if (redirect) begin
                    flush_id      = 1'b1;
                    flush_ex      = redir_fex;
                    misalign_trap = misalign;
                    redir_d       = tgt;
                    if (imem_ack) begin
                        npc     = tgt;
                        state_d = ISSUE;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    if_valid = 1'b1;
                    npc      = pc_inc;
                    state_d  = ISSUE;
                end
            end
            DRAIN: begin
                // Outstanding fetch is discarded; latest redirect wins.
                imem_req = 1'b1;
                if (redirect) begin
                    flush_id      = 1'b1;
                    flush_ex      = redir_fex;
                    misalign_trap = misalign;
                    redir_d       = tgt;
                end
                if (imem_ack) begin
                    npc     = redirect ? tgt : redir_q;
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard testbench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_pc = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = '0;
    logic        trap_en = 1'b0;
    logic [31:0] trap_vec = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        if_valid;
    logic        flush_id;
    logic        flush_ex;
    logic        misalign_trap;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [69:0] v;
    } exp_t;

    exp_t sb[$];

    logic [31:0] p;

    pc_sequencer #(
        .WIDTH_PC (32),
        .BOOT_ADDR(32'h0),
        .PC_STEP  (32'h4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .npc          (npc),
        .stall        (stall),
        .jump_en      (jump_en),
        .jump_pc      (jump_pc),
        .br_taken     (br_taken),
        .br_pc        (br_pc),
        .trap_en      (trap_en),
        .trap_vec     (trap_vec),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .if_valid     (if_valid),
        .flush_id     (flush_id),
        .flush_ex     (flush_ex),
        .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    // PC register model: samples npc each cycle, resets to -4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'hFFFF_FFFC;
        else        pc <= npc;
    end

    // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t        e;
            logic [69:0] act;
            e   = sb.pop_front();
            act = {npc, imem_req, imem_addr, if_valid, flush_id, flush_ex, misalign_trap};
            n_checks++;
            if (act !== e.v) begin
                n_fail++;
                $display("FAIL %s: {npc,req,addr,ifv,fid,fex,mis} actual=%h required=%h", e.name, act, e.v);
            end
        end
    end

    task automatic exp(input string nm, input logic [31:0] e_npc, input logic e_req,
                       input logic [31:0] e_addr, input logic e_ifv, input logic e_fid,
                       input logic e_fex, input logic e_mis);
        exp_t e;
        e.name = nm;
        e.v    = {e_npc, e_req, e_addr, e_ifv, e_fid, e_fex, e_mis};
        sb.push_back(e);
        @(posedge clk);
        #1;
        stall    = 1'b0;
        jump_en  = 1'b0;
        br_taken = 1'b0;
        trap_en  = 1'b0;
        imem_ack = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp("reset", 32'h0, 0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // sequential fetch, ack every cycle (ack in BOOT ignored)
        imem_ack = 1; exp("boot", 32'h0, 0, 32'h0, 0, 0, 0, 0);
        imem_ack = 1; exp("seq0", 32'h4, 1, 32'h0, 1, 0, 0, 0);
        imem_ack = 1; exp("seq1", 32'h8, 1, 32'h4, 1, 0, 0, 0);

        // delayed ack at pc=8
        exp("wait0", 32'h8, 1, 32'h8, 0, 0, 0, 0);
        exp("wait1", 32'h8, 1, 32'h8, 0, 0, 0, 0);
        stall = 1; exp("wait2_stall_ignored", 32'h8, 1, 32'h8, 0, 0, 0, 0);
        imem_ack = 1; exp("wait_ack", 32'hC, 1, 32'h8, 1, 0, 0, 0);

        // branch beats jump in ISSUE
        br_taken = 1; br_pc = 32'h40; jump_en = 1; jump_pc = 32'h80;
        exp("br_over_jump", 32'h40, 0, 32'h0, 0, 1, 1, 0);
        imem_ack = 1; exp("after_br", 32'h44, 1, 32'h40, 1, 0, 0, 0);

        // jump during WAIT -> DRAIN
        exp("issue_noack", 32'h44, 1, 32'h44, 0, 0, 0, 0);
        jump_en = 1; jump_pc = 32'h100;
        exp("wait_jump", 32'h44, 1, 32'h44, 0, 1, 0, 0);
        exp("drain", 32'h44, 1, 32'h44, 0, 0, 0, 0);
        imem_ack = 1; exp("drain_ack", 32'h100, 1, 32'h44, 0, 0, 0, 0);

        // stall with trap mid-stall
        stall = 1; exp("stall0", 32'h100, 0, 32'h0, 0, 0, 0, 0);
        stall = 1; imem_ack = 1; exp("stall1_ack_ignored", 32'h100, 0, 32'h0, 0, 0, 0, 0);
        stall = 1; trap_en = 1; trap_vec = 32'h200;
        exp("stall_trap", 32'h200, 0, 32'h0, 0, 1, 1, 0);
        stall = 1; exp("stall3", 32'h200, 0, 32'h0, 0, 0, 0, 0);
        imem_ack = 1; exp("unstall", 32'h204, 1, 32'h200, 1, 0, 0, 0);

        // wrap at top of address space
        jump_en = 1; jump_pc = 32'hFFFF_FFFC;
        exp("jump_top", 32'hFFFF_FFFC, 0, 32'h0, 0, 1, 0, 0);
        imem_ack = 1; exp("wrap", 32'h0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);

        // misaligned branch target
        br_taken = 1; br_pc = 32'h42; trap_vec = 32'h300;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        p = 32'h300;
        exp("misalign", p, 0, 32'h0, 0, 1, 1, 1);
`else
        p = 32'h40;
        exp("misalign", p, 0, 32'h0, 0, 1, 1, 0);
`endif
        imem_ack = 1; exp("after_misalign", p + 32'h4, 1, p, 1, 0, 0, 0);
        p = p + 32'h4;

        // latest redirect wins in DRAIN
        exp("issue_noack2", p, 1, p, 0, 0, 0, 0);
        br_taken = 1; br_pc = 32'h500;
        exp("wait_br", p, 1, p, 0, 1, 1, 0);
        jump_en = 1; jump_pc = 32'h600;
        exp("drain_jump", p, 1, p, 0, 1, 0, 0);
        imem_ack = 1; exp("drain_ack2", 32'h600, 1, p, 0, 0, 0, 0);

        // redirect and ack same cycle in WAIT
        exp("issue_noack3", 32'h600, 1, 32'h600, 0, 0, 0, 0);
        trap_en = 1; trap_vec = 32'h700; imem_ack = 1;
        exp("wait_trap_ack", 32'h700, 1, 32'h600, 0, 1, 1, 0);
        imem_ack = 1; exp("after_trap", 32'h704, 1, 32'h700, 1, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_scoreboard: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
